// File: rtl/mul8_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul8_seq_pkg
// Shared types and constants for the sequential 8x8 multiplier controller.
//   state_t     : controller state (IDLE, MUL, DONE)
//   step_t      : partial-product step index 0..3
//   shift/select constants for the four partial products
//   helper functions for the optional zero-skip step mask
// Optional feature macro: MUL8_SEQ_ZERO_SKIP_EN (the helpers are only used
// when it is defined).
// -----------------------------------------------------------------------------
package mul8_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] step_t;

  // Left shift applied to each step's partial product.
  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  // Nibble-select encodings: bit i set means step i uses the high nibble.
  //   step0 a_lo*b_lo, step1 a_lo*b_hi, step2 a_hi*b_lo, step3 a_hi*b_hi
  localparam logic [3:0] A_HI_SEL = 4'b1100;
  localparam logic [3:0] B_HI_SEL = 4'b1010;

  function automatic logic [3:0] step_shift(input step_t s);
    case (s)
      2'd0:    return SHIFT_S0;
      2'd1:    return SHIFT_S1;
      2'd2:    return SHIFT_S2;
      default: return SHIFT_S3;
    endcase
  endfunction

  // A step is active when both of its operand nibbles are nonzero.
  function automatic logic [3:0] active_mask(input logic [7:0] a,
                                             input logic [7:0] b);
    logic a_lo, a_hi, b_lo, b_hi;
    a_lo = |a[3:0];
    a_hi = |a[7:4];
    b_lo = |b[3:0];
    b_hi = |b[7:4];
    return {a_hi & b_hi, a_hi & b_lo, a_lo & b_hi, a_lo & b_lo};
  endfunction

  // Lowest active step; step0 when the mask is empty so one step always runs.
  function automatic step_t first_step(input logic [3:0] mask);
    if (mask[0])      return 2'd0;
    else if (mask[1]) return 2'd1;
    else if (mask[2]) return 2'd2;
    else if (mask[3]) return 2'd3;
    else              return 2'd0;
  endfunction

  // Lowest active step strictly after cur; {found, index}.
  function automatic logic [2:0] next_step(input logic [3:0] mask,
                                           input step_t      cur);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 1; i--) begin
      if (mask[i] && (2'(i) > cur)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_multi4.sv
// -----------------------------------------------------------------------------
// multi4
// Combinational 4x4 unsigned nibble multiplier shared by all partial-product
// steps of mul8_seq_ctrl.
//   a : in  4  multiplicand nibble
//   b : in  4  multiplier nibble
//   p : out 8  product a*b
// -----------------------------------------------------------------------------
module multi4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mul8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul8_seq_ctrl
// Sequential 8x8 unsigned multiplier. One 4x4 nibble multiplier is reused for
// the four partial products, which are shifted and accumulated into a 16-bit
// product. Valid/ready handshakes on input and output.
//   clk       : in  1   rising-edge clock
//   rst_n     : in  1   asynchronous active-low reset
//   in_valid  : in  1   operand pair presented
//   in_ready  : out 1   operands accepted this cycle when in_valid
//   a, b      : in  8   unsigned operands
//   out_valid : out 1   product available
//   out_ready : in  1   consumer takes product this cycle
//   out       : out 16  product a*b
//   busy      : out 1   high while partial products are being accumulated
// Optional feature macro: MUL8_SEQ_ZERO_SKIP_EN -- skip steps whose operand
// nibbles contain a zero (latency max(1, active steps)); undefined runs all
// four steps with fixed latency 4.
// -----------------------------------------------------------------------------
module mul8_seq_ctrl
  import mul8_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        busy
);

  state_t      state;
  step_t       step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
  logic [3:0]  mask_q;
`endif

  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic        accept;
  logic        has_next;
  step_t       nxt_step;
  step_t       start_step;

  // Outputs decode directly from registered state / accumulator.
  assign busy      = (state == MUL);
  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out       = acc;
  assign accept    = in_valid && in_ready;

  // Nibble muxes feeding the shared multiplier, selected by the current step.
  assign nib_a = A_HI_SEL[step] ? a_q[7:4] : a_q[3:0];
  assign nib_b = B_HI_SEL[step] ? b_q[7:4] : b_q[3:0];

  multi4 u_multi4 (
    .a (nib_a),
    .b (nib_b),
    .p (pp)
  );

  assign pp_shifted = {8'h00, pp} << step_shift(step);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    has_next   = 1'b0;
    nxt_step   = 2'd0;
    start_step = 2'd0;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
    {has_next, nxt_step} = next_step(mask_q, step);
    start_step           = first_step(active_mask(a, b));
`else
    has_next = (step != 2'd3);
    nxt_step = step + 2'd1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others; the async reset clears all
  // state, discarding any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      acc   <= 16'h0000;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
      mask_q <= 4'h0;
`endif
    end else if (accept) begin
      // Covers both IDLE and the back-to-back accept out of DONE.
      state <= MUL;
      step  <= start_step;
      a_q   <= a;
      b_q   <= b;
      acc   <= 16'h0000;
`ifdef MUL8_SEQ_ZERO_SKIP_EN
      mask_q <= active_mask(a, b);
`endif
    end else begin
      case (state)
        MUL: begin
          acc <= acc + pp_shifted;
          if (has_next) begin
            step <= nxt_step;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul8_seq_ctrl
// Directed self-checking bench for mul8_seq_ctrl. Expected latencies depend on
// MUL8_SEQ_ZERO_SKIP_EN, which is honoured here as well.
// -----------------------------------------------------------------------------
module tb_mul8_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mul8_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands; they are accepted on the next rising edge.
  task automatic present(input string tag, input logic [7:0] av,
                         input logic [7:0] bv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  // Count cycles from the accept edge until out_valid, then check the result.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [15:0] exp_out);
    int cnt;
    cnt = 1;
    tick();
    while (!out_valid && cnt < 20) begin
      check({tag, "_no_valid_while_busy"}, 32'(busy), 32'd1);
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_busy_low_in_done"}, 32'(busy), 32'd0);
  endtask

`ifdef MUL8_SEQ_ZERO_SKIP_EN
  localparam int LAT_0F0F = 1;
  localparam int LAT_0055 = 1;
  localparam int LAT_F011 = 2;
  localparam int LAT_0305 = 1;
  localparam int LAT_8002 = 1;
`else
  localparam int LAT_0F0F = 4;
  localparam int LAT_0055 = 4;
  localparam int LAT_F011 = 4;
  localparam int LAT_0305 = 4;
  localparam int LAT_8002 = 4;
`endif

  initial begin
    int seen_valid;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;

    // Reset values before any clock edge.
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // FF*FF, consumer ready: product then back to IDLE.
    out_ready = 1'b1;
    present("ffff", 8'hFF, 8'hFF);
    wait_done("ffff", 4, 16'hFE01);
    check("ffff_in_ready_done", 32'(in_ready), 32'd1);
    tick();
    check("ffff_idle_out_valid", 32'(out_valid), 32'd0);
    check("ffff_idle_in_ready", 32'(in_ready), 32'd1);
    check("ffff_out_held", 32'(out), 32'hFE01);

    // 12*34 with backpressure; other operands offered and ignored.
    out_ready = 1'b0;
    present("1234", 8'h12, 8'h34);
    wait_done("1234", 4, 16'h03A8);
    in_valid = 1'b1;
    a        = 8'h77;
    b        = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("1234_stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("1234_stall_valid", 32'(out_valid), 32'd1);
      check("1234_stall_out", 32'(out), 32'h03A8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("1234_consumed", 32'(out_valid), 32'd0);
    check("1234_idle_busy", 32'(busy), 32'd0);

    // Back-to-back: accept 03*05 on the same edge the product is taken.
    present("2211", 8'h22, 8'h11);
    wait_done("2211", 4, 16'h0242);
    in_valid = 1'b1;
    a        = 8'h03;
    b        = 8'h05;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_out_valid", 32'(out_valid), 32'd0);
    check("b2b_in_ready_busy", 32'(in_ready), 32'd0);
    wait_done("b2b", LAT_0305, 16'h000F);
    tick();

    // Reset pulsed during step2 of AB*CD: nothing is produced for it.
    present("abcd", 8'hAB, 8'hCD);
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out", 32'(out), 32'h0000);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen_valid = 1;
    end
    check("mid_rst_no_valid", 32'(seen_valid), 32'd0);
    present("8002", 8'h80, 8'h02);
    wait_done("8002", LAT_8002, 16'h0100);
    tick();

    // Zero-nibble operands (skipped steps when the feature is built in).
    present("0f0f", 8'h0F, 8'h0F);
    wait_done("0f0f", LAT_0F0F, 16'h00E1);
    tick();
    present("0055", 8'h00, 8'h55);
    wait_done("0055", LAT_0055, 16'h0000);
    tick();
    present("f011", 8'hF0, 8'h11);
    wait_done("f011", LAT_F011, 16'h0FF0);
    tick();
    check("final_idle", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
